// File: rtl/vex_uop_sequencer_if.sv
// Issue-side and vex-side handshake bundle of the uop sequencer.
// slave = the sequencer itself, master = whoever drives issue and models vex.
interface vex_uop_sequencer_if #(
  parameter int VECTOR_REGISTERS   = 32,
  parameter int VECTOR_LANES       = 8,
  parameter int MAX_VL             = 32,
  parameter int VECTOR_TICKET_BITS = 5
);
  localparam int DST_W = $clog2(VECTOR_REGISTERS);
  localparam int VL_W  = $clog2(MAX_VL) + 1;
  localparam int NU    = MAX_VL / VECTOR_LANES;
  localparam int IDX_W = (NU > 1) ? $clog2(NU) : 1;

  // Both handshakes: a transfer happens on a cycle where valid & ready are high;
  // the offering side holds its payload stable until that cycle.
  logic                          instr_valid_i;
  logic                          instr_ready_o;
  logic [VL_W-1:0]               instr_vl_i;
  logic [DST_W-1:0]              instr_dst_i;
  logic [VECTOR_TICKET_BITS-1:0] instr_ticket_i;
  logic                          instr_rdc_i;

  logic                          uop_valid_o;
  logic                          uop_ready_i;
  logic [DST_W-1:0]              uop_dst_o;
  logic [VECTOR_TICKET_BITS-1:0] uop_ticket_o;
  logic                          uop_head_o;
  logic                          uop_end_o;
  logic [VECTOR_LANES-1:0]       uop_lane_en_o;
  logic [IDX_W-1:0]              uop_idx_o;

  logic                          vex_idle_i;

  modport slave (
    input  instr_valid_i, instr_vl_i, instr_dst_i, instr_ticket_i, instr_rdc_i,
    output instr_ready_o,
    output uop_valid_o, uop_dst_o, uop_ticket_o, uop_head_o, uop_end_o,
    output uop_lane_en_o, uop_idx_o,
    input  uop_ready_i, vex_idle_i
  );

  modport master (
    output instr_valid_i, instr_vl_i, instr_dst_i, instr_ticket_i, instr_rdc_i,
    input  instr_ready_o,
    input  uop_valid_o, uop_dst_o, uop_ticket_o, uop_head_o, uop_end_o,
    input  uop_lane_en_o, uop_idx_o,
    output uop_ready_i, vex_idle_i
  );
endinterface

// File: rtl/vex_uop_sequencer.sv
// Splits one vector instruction into ceil(vl/VECTOR_LANES) uops for vex,
// draining the vex pipeline around reduction instructions.
module vex_uop_sequencer #(
  parameter int VECTOR_REGISTERS   = 32,
  parameter int VECTOR_LANES       = 8,
  parameter int MAX_VL             = 32,
  parameter int VECTOR_TICKET_BITS = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  vex_uop_sequencer_if.slave bus,
  output logic              busy_o,
  output logic [1:0]        state_dbg
);
  localparam int DST_W = $clog2(VECTOR_REGISTERS);
  localparam int VL_W  = $clog2(MAX_VL) + 1;
  localparam int NU    = MAX_VL / VECTOR_LANES;
  localparam int IDX_W = (NU > 1) ? $clog2(NU) : 1;
  localparam int LOG_L = $clog2(VECTOR_LANES);
  localparam int NU_W  = VL_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;

  localparam logic [VL_W-1:0]  MAX_VL_V = VL_W'(MAX_VL);
  localparam logic [DST_W:0]   NREG_V   = (DST_W+1)'(VECTOR_REGISTERS);

  logic [1:0]                    state;
  logic [VL_W-1:0]               vl_q;
  logic [DST_W-1:0]              dst_q;
  logic [VECTOR_TICKET_BITS-1:0] ticket_q;
  logic                          rdc_q;
  logic [IDX_W-1:0]              idx_q;
  logic                          rdc_pending;

  logic             accept;
  logic             issue;
  logic             fire;
  logic             is_end;
  logic [NU_W-1:0]  nuops;
  logic [NU_W-1:0]  idx_w;
  logic [NU_W-1:0]  base;
  logic [DST_W:0]   dst_sum;
  logic [DST_W-1:0] dst_mod;

  assign issue     = (state == S_ISSUE);
  assign state_dbg = state;
  assign busy_o    = (state != S_IDLE) | rdc_pending;

  // Ready is forced low while reset is held so nothing is taken during reset.
  assign bus.instr_ready_o = rst_n & (state == S_IDLE) & (~rdc_pending | bus.vex_idle_i);
  assign accept            = bus.instr_valid_i & bus.instr_ready_o;
  assign fire              = issue & bus.uop_ready_i;

  always_comb begin
    nuops   = ({1'b0, vl_q} + NU_W'(VECTOR_LANES - 1)) >> LOG_L;
    idx_w   = NU_W'(idx_q);
    base    = idx_w << LOG_L;
    is_end  = (idx_w == (nuops - NU_W'(1)));
    dst_sum = {1'b0, dst_q} + (DST_W+1)'(idx_q);
    dst_mod = (dst_sum >= NREG_V) ? DST_W'(dst_sum - NREG_V) : dst_sum[DST_W-1:0];
  end

  // Every uop field is zero whenever no uop is presented.
  always_comb begin
    bus.uop_valid_o   = 1'b0;
    bus.uop_dst_o     = '0;
    bus.uop_ticket_o  = '0;
    bus.uop_head_o    = 1'b0;
    bus.uop_end_o     = 1'b0;
    bus.uop_lane_en_o = '0;
    bus.uop_idx_o     = '0;
    if (issue) begin
      bus.uop_valid_o  = 1'b1;
      bus.uop_dst_o    = dst_mod;
      bus.uop_ticket_o = ticket_q;
      bus.uop_head_o   = (idx_q == '0);
      bus.uop_end_o    = is_end;
      bus.uop_idx_o    = idx_q;
      for (int k = 0; k < VECTOR_LANES; k++) begin
        bus.uop_lane_en_o[k] = ((base + NU_W'(k)) < {1'b0, vl_q});
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      vl_q        <= '0;
      dst_q       <= '0;
      ticket_q    <= '0;
      rdc_q       <= 1'b0;
      idx_q       <= '0;
      rdc_pending <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            vl_q        <= bus.instr_vl_i;
            dst_q       <= bus.instr_dst_i;
            ticket_q    <= bus.instr_ticket_i;
            rdc_q       <= bus.instr_rdc_i;
            idx_q       <= '0;
            rdc_pending <= 1'b0;
            // A zero-length instruction is consumed without producing uops.
            if (bus.instr_vl_i == '0)  state <= S_IDLE;
            else if (bus.instr_rdc_i)  state <= S_DRAIN;
            else                       state <= S_ISSUE;
          end
        end
        S_DRAIN: begin
          if (bus.vex_idle_i) state <= S_ISSUE;
        end
        S_ISSUE: begin
          if (fire) begin
            if (is_end) begin
              state       <= S_IDLE;
              rdc_pending <= rdc_q;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  a_vl_legal: assert property (@(posedge clk) disable iff (!rst_n)
    accept |-> (bus.instr_vl_i <= MAX_VL_V));

endmodule

// File: tb/tb_vex_uop_sequencer.sv
// Directed bench for vex_uop_sequencer with hand-computed expectations
// (VECTOR_LANES=8, MAX_VL=32, 32 registers, 5-bit tickets).
module tb_vex_uop_sequencer;
  logic       clk;
  logic       rst_n;
  logic       busy;
  logic [1:0] state_dbg;
  int         errors;
  int         checks;

  vex_uop_sequencer_if #(
    .VECTOR_REGISTERS(32), .VECTOR_LANES(8), .MAX_VL(32), .VECTOR_TICKET_BITS(5)
  ) bus ();

  vex_uop_sequencer #(
    .VECTOR_REGISTERS(32), .VECTOR_LANES(8), .MAX_VL(32), .VECTOR_TICKET_BITS(5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .busy_o    (busy),
    .state_dbg (state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the active edge; outputs are sampled on the falling edge.
  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk_uop(input string tag, input logic [4:0] dst, input logic [4:0] ticket,
                         input logic head, input logic last, input logic [7:0] lane,
                         input logic [1:0] idx);
    check({tag, "_valid"},  {31'd0, bus.uop_valid_o}, 32'd1);
    check({tag, "_dst"},    {27'd0, bus.uop_dst_o}, {27'd0, dst});
    check({tag, "_ticket"}, {27'd0, bus.uop_ticket_o}, {27'd0, ticket});
    check({tag, "_head"},   {31'd0, bus.uop_head_o}, {31'd0, head});
    check({tag, "_end"},    {31'd0, bus.uop_end_o}, {31'd0, last});
    check({tag, "_lane"},   {24'd0, bus.uop_lane_en_o}, {24'd0, lane});
    check({tag, "_idx"},    {30'd0, bus.uop_idx_o}, {30'd0, idx});
  endtask

  task automatic chk_quiet(input string tag);
    check({tag, "_valid"}, {31'd0, bus.uop_valid_o}, 32'd0);
    check({tag, "_dst"},   {27'd0, bus.uop_dst_o}, 32'd0);
    check({tag, "_lane"},  {24'd0, bus.uop_lane_en_o}, 32'd0);
    check({tag, "_hdend"}, {30'd0, bus.uop_head_o, bus.uop_end_o}, 32'd0);
  endtask

  // Driver: offer one instruction, confirm it is taken on the next edge.
  task automatic send(input string tag, input logic [5:0] vl, input logic [4:0] dst,
                      input logic [4:0] ticket, input logic rdc);
    bus.instr_valid_i  = 1'b1;
    bus.instr_vl_i     = vl;
    bus.instr_dst_i    = dst;
    bus.instr_ticket_i = ticket;
    bus.instr_rdc_i    = rdc;
    smp();
    check({tag, "_accept_ready"}, {31'd0, bus.instr_ready_o}, 32'd1);
    adv();
    bus.instr_valid_i  = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    bus.instr_valid_i  = 1'b0;
    bus.instr_vl_i     = '0;
    bus.instr_dst_i    = '0;
    bus.instr_ticket_i = '0;
    bus.instr_rdc_i    = 1'b0;
    bus.uop_ready_i    = 1'b1;
    bus.vex_idle_i     = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    smp();
    check("rst_ready", {31'd0, bus.instr_ready_o}, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    chk_quiet("rst");
    adv();
    rst_n = 1'b1;
    smp();
    check("post_rst_ready", {31'd0, bus.instr_ready_o}, 32'd1);
    check("post_rst_state", {30'd0, state_dbg}, 32'd0);
    adv();

    // vl=20, dst=4, ticket=3: three back-to-back uops
    send("v20", 6'd20, 5'd4, 5'd3, 1'b0);
    smp(); chk_uop("v20_u0", 5'd4, 5'd3, 1'b1, 1'b0, 8'hFF, 2'd0);
    check("v20_busy", {31'd0, busy}, 32'd1);
    check("v20_ready_lo", {31'd0, bus.instr_ready_o}, 32'd0);
    adv(); smp(); chk_uop("v20_u1", 5'd5, 5'd3, 1'b0, 1'b0, 8'hFF, 2'd1);
    adv(); smp(); chk_uop("v20_u2", 5'd6, 5'd3, 1'b0, 1'b1, 8'h0F, 2'd2);
    adv(); smp();
    chk_quiet("v20_done");
    check("v20_ready_back", {31'd0, bus.instr_ready_o}, 32'd1);
    check("v20_busy_off", {31'd0, busy}, 32'd0);
    adv();

    // vl=32, dst=30: destination wraps 31 -> 0
    send("v32", 6'd32, 5'd30, 5'd17, 1'b0);
    smp(); chk_uop("v32_u0", 5'd30, 5'd17, 1'b1, 1'b0, 8'hFF, 2'd0);
    adv(); smp(); chk_uop("v32_u1", 5'd31, 5'd17, 1'b0, 1'b0, 8'hFF, 2'd1);
    adv(); smp(); chk_uop("v32_u2", 5'd0,  5'd17, 1'b0, 1'b0, 8'hFF, 2'd2);
    adv(); smp(); chk_uop("v32_u3", 5'd1,  5'd17, 1'b0, 1'b1, 8'hFF, 2'd3);
    adv(); smp(); chk_quiet("v32_done");
    adv();

    // vl=16 with vex stalling idx0 for 3 cycles
    bus.uop_ready_i = 1'b0;
    send("v16", 6'd16, 5'd10, 5'd1, 1'b0);
    smp(); chk_uop("v16_stall1", 5'd10, 5'd1, 1'b1, 1'b0, 8'hFF, 2'd0);
    adv(); smp(); chk_uop("v16_stall2", 5'd10, 5'd1, 1'b1, 1'b0, 8'hFF, 2'd0);
    adv(); smp(); chk_uop("v16_stall3", 5'd10, 5'd1, 1'b1, 1'b0, 8'hFF, 2'd0);
    adv(); bus.uop_ready_i = 1'b1;
    smp(); chk_uop("v16_go", 5'd10, 5'd1, 1'b1, 1'b0, 8'hFF, 2'd0);
    adv(); smp(); chk_uop("v16_u1", 5'd11, 5'd1, 1'b0, 1'b1, 8'hFF, 2'd1);
    adv(); smp(); chk_quiet("v16_done");
    adv();

    // Single partial uop: head and end together
    send("v4", 6'd4, 5'd7, 5'd2, 1'b0);
    smp(); chk_uop("v4_u0", 5'd7, 5'd2, 1'b1, 1'b1, 8'h0F, 2'd0);
    adv(); smp(); chk_quiet("v4_done");
    adv();

    // Reduction, vl=8, vex busy for 4 cycles after accept
    bus.vex_idle_i = 1'b0;
    send("rdc", 6'd8, 5'd2, 5'd9, 1'b1);
    for (int i = 0; i < 4; i++) begin
      smp();
      check("rdc_drain_valid", {31'd0, bus.uop_valid_o}, 32'd0);
      check("rdc_drain_ready", {31'd0, bus.instr_ready_o}, 32'd0);
      check("rdc_drain_busy",  {31'd0, busy}, 32'd1);
      adv();
    end
    bus.vex_idle_i = 1'b1;
    smp(); check("rdc_idle_edge_valid", {31'd0, bus.uop_valid_o}, 32'd0);
    adv(); bus.vex_idle_i = 1'b0;
    smp(); chk_uop("rdc_u0", 5'd2, 5'd9, 1'b1, 1'b1, 8'hFF, 2'd0);
    adv();
    // Follow-on instruction must wait for vex to drain the reduction
    bus.instr_valid_i  = 1'b1;
    bus.instr_vl_i     = 6'd8;
    bus.instr_dst_i    = 5'd0;
    bus.instr_ticket_i = 5'd4;
    bus.instr_rdc_i    = 1'b0;
    smp(); check("rdc_pend_ready0", {31'd0, bus.instr_ready_o}, 32'd0);
    check("rdc_pend_busy", {31'd0, busy}, 32'd1);
    chk_quiet("rdc_pend0");
    adv(); smp(); check("rdc_pend_ready1", {31'd0, bus.instr_ready_o}, 32'd0);
    adv(); bus.vex_idle_i = 1'b1;
    smp(); check("rdc_pend_release", {31'd0, bus.instr_ready_o}, 32'd1);
    adv(); bus.instr_valid_i = 1'b0;
    smp(); chk_uop("after_rdc_u0", 5'd0, 5'd4, 1'b1, 1'b1, 8'hFF, 2'd0);
    adv(); smp(); chk_quiet("after_rdc_done");
    check("after_rdc_busy", {31'd0, busy}, 32'd0);
    adv();

    // vl=0 is consumed without any uop
    send("v0", 6'd0, 5'd3, 5'd6, 1'b0);
    smp();
    chk_quiet("v0");
    check("v0_busy",  {31'd0, busy}, 32'd0);
    check("v0_ready", {31'd0, bus.instr_ready_o}, 32'd1);
    adv();

    // Asynchronous reset during idx1 of a vl=24 instruction
    send("v24", 6'd24, 5'd20, 5'd5, 1'b0);
    smp(); chk_uop("v24_u0", 5'd20, 5'd5, 1'b1, 1'b0, 8'hFF, 2'd0);
    adv(); smp(); chk_uop("v24_u1", 5'd21, 5'd5, 1'b0, 1'b0, 8'hFF, 2'd1);
    #1 rst_n = 1'b0;
    #1;
    chk_quiet("arst");
    check("arst_ready", {31'd0, bus.instr_ready_o}, 32'd0);
    check("arst_busy",  {31'd0, busy}, 32'd0);
    check("arst_idx",   {30'd0, bus.uop_idx_o}, 32'd0);
    adv(); adv();
    rst_n = 1'b1;
    smp(); chk_quiet("arst_rel0");
    check("arst_rel_ready", {31'd0, bus.instr_ready_o}, 32'd1);
    adv(); smp(); chk_quiet("arst_rel1");
    check("arst_rel_state", {30'd0, state_dbg}, 32'd0);
    adv();

    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vex_uop_sequencer.md
Name: vex_uop_sequencer

Overview:
- Sits between vector issue and the vector execution stage (vex).
- Accepts one vector instruction at a time (vl, destination, ticket, reduction flag) and splits it into ceil(vl/VECTOR_LANES) micro-ops, one per register of the group.
- Drives per-uop valid, destination, ticket, head/end flags and lane enables into vex, and honours vex's ready backpressure.
- Serialises reductions by draining the vex pipeline before a reduction issues and again before the next instruction issues after it.

Parameters:
- VECTOR_REGISTERS, 32, architectural vector register count; dst width = $clog2(VECTOR_REGISTERS).
- VECTOR_LANES, 8, elements per uop; power of two, ≥2.
- MAX_VL, 32, maximum vl; multiple of VECTOR_LANES.
- VECTOR_TICKET_BITS, 5, ticket width.
- Derived: VL_W = $clog2(MAX_VL)+1; IDX_W = max(1, $clog2(MAX_VL/VECTOR_LANES)).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid_i  in  1  instruction offered.
- instr_ready_o  out  1  instruction accepted when valid&ready.
- instr_vl_i  in  VL_W  element count, 0..MAX_VL.
- instr_dst_i  in  $clog2(VECTOR_REGISTERS)  base destination register.
- instr_ticket_i  in  VECTOR_TICKET_BITS  instruction ticket.
- instr_rdc_i  in  1  reduction instruction.
- uop_valid_o  out  1  uop presented to vex.
- uop_ready_i  in  1  vex ready (ANDed lane ready).
- uop_dst_o  out  $clog2(VECTOR_REGISTERS)  uop destination register.
- uop_ticket_o  out  VECTOR_TICKET_BITS  ticket, constant across the instruction.
- uop_head_o  out  1  first uop of the instruction.
- uop_end_o  out  1  last uop of the instruction.
- uop_lane_en_o  out  VECTOR_LANES  per-lane element valid.
- uop_idx_o  out  IDX_W  uop index within the instruction.
- vex_idle_i  in  1  vex pipeline empty.
- busy_o  out  1  state≠IDLE or rdc_pending.

Behaviour:
- Reset: state=IDLE, rdc_pending=0.
  - All uop_* outputs = 0.
  - instr_ready_o=1 once rst_n deasserts; while rst_n is asserted it is 0 with busy_o=0.
  - Reset mid-instruction aborts it with no further uops.
- FSM states: IDLE, DRAIN, ISSUE.
- IDLE:
  - instr_ready_o = ~rdc_pending | vex_idle_i.
  - On accept, register vl, dst, ticket and rdc; clear idx and rdc_pending.
  - vl==0: consume and stay in IDLE; no uop is issued.
  - rdc=1: go to DRAIN.
  - Otherwise go to ISSUE (first uop_valid appears the cycle after accept).
- DRAIN: hold uop_valid_o=0; go to ISSUE on the first cycle vex_idle_i=1. That can be the cycle right after accept.
- ISSUE:
  - uop_valid_o=1.
  - uop_dst_o = (dst_base + idx) mod VECTOR_REGISTERS, i.e. wraps from 31 to 0.
  - uop_head_o = (idx==0).
  - uop_end_o = (idx==nuops-1), where nuops = ceil(vl/VECTOR_LANES).
  - uop_lane_en_o[k] = (idx*VECTOR_LANES + k < vl).
  - A single-uop instruction asserts head and end together.
  - Handshake on uop_valid_o & uop_ready_i. All uop outputs stay stable while stalled.
  - Non-end handshake: idx++.
  - End handshake: go to IDLE; set rdc_pending = rdc.
- No accept in the same cycle as the end handshake; instr_ready_o=0 in DRAIN and ISSUE. Minimum throughput is one instruction per nuops+1 cycles.
- rdc_pending: blocks the next accept until vex_idle_i=1.
- All uop outputs are driven 0 whenever uop_valid_o=0.
- Arithmetic: nuops = (vl + VECTOR_LANES-1) >> log2(VECTOR_LANES), computed at VL_W+1 bits. vl>MAX_VL is illegal; the SVA flags it.

Test Plan (VECTOR_LANES=8, MAX_VL=32):
- vl=20, dst=4, ticket=3, uop_ready_i=1:
  - uops on 3 consecutive cycles with dst=4,5,6 and idx=0,1,2.
  - head only on idx0, end only on idx2.
  - lane_en=FF,FF,0F; ticket=3 throughout.
  - instr_ready_o is back to 1 the cycle after idx2.
- vl=32, dst=30: dst=30,31,0,1 (wrap); lane_en=FF on all four uops.
- vl=16 with uop_ready_i=0 for 3 cycles on idx0:
  - idx0 fields held stable for 4 cycles.
  - Total of 5 cycles from first uop_valid to end.
- rdc=1, vl=8 with vex_idle_i=0 for 4 cycles:
  - No uop_valid during the drain.
  - One uop with head=end=1 and lane_en=FF on the cycle after vex_idle_i rises.
  - The next instruction waits for vex_idle_i=1 before instr_ready_o=1.
- vl=0: accepted in one cycle; no uop_valid; busy_o stays 0.
- rst_n asserted during idx1 of a vl=24 instruction: all outputs 0 asynchronously; after release, no uop until a new instruction is accepted.
